uart_tx_stream: RTL and testbench
=================================

# uart_tx_stream

Parametrised UART transmitter with an input FIFO and a valid/ready byte stream interface, driving the serial TX pin. It replaces the fixed 8N1 transmitter: one clock domain (baud timing by enable counter, no derived clock), configurable frame format and baud divisor, and gap-free back-to-back frames. It sits between the CPU-side MMIO/stream logic and the board TX pin.

## Interface
- CLKS_PER_BIT, 217: clock cycles per serial bit; legal range 2..65535.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: entries; power of two, at least 2.

- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  DATA_BITS  word to send; sampled when tx_valid && tx_ready.
- tx_valid  input  1  producer has a word.
- tx_ready  output  1  FIFO can accept; equals (fifo_count < FIFO_DEPTH).
- fifo_count  output  $clog2(FIFO_DEPTH)+1  words queued, excluding the word in flight.
- busy  output  1  high while the FSM is not IDLE or fifo_count != 0.
- tx_pin  output  1  serial line; idle high.

## Operation
- Reset values: tx_pin=1, tx_ready=1, busy=0, fifo_count=0, FSM=IDLE, baud counter=0, FIFO pointers=0. Any queued or in-flight word is discarded.
- FIFO: push on valid&&ready; pop by the FSM only. When push and pop happen on the same edge, fifo_count is unchanged. When full, tx_ready=0 and tx_valid is ignored; no overwrite. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_pin=1. If fifo_count!=0, pop the head into the shift register, tx_pin<=0, baud counter<=0, go to START.
  - START, DATA, PARITY, STOP: each bit holds for exactly CLKS_PER_BIT clocks. The baud counter counts 0..CLKS_PER_BIT-1, and the bit advances on the cycle the counter is CLKS_PER_BIT-1.
  - DATA: DATA_BITS bits, LSB first; bit index 0..DATA_BITS-1.
  - PARITY: entered only if PARITY!=0. Odd: the bit makes the total count of ones in data plus parity odd. Even: it makes that count even. Parity is computed from the popped word.
  - STOP: tx_pin=1 for STOP_BITS*CLKS_PER_BIT clocks.
- End of the last stop cycle: if the FIFO is non-empty, pop and go directly to START, with tx_pin<=0 on that same edge and no idle bit. Otherwise go to IDLE.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT clocks.
- tx_pin is a registered output and never glitches.

## Timing
- Acceptance at edge N with an empty FIFO and FSM in IDLE: fifo_count=1 after N. At edge N+1 the FSM pops: tx_pin falls and fifo_count=0 after N+1. The start bit spans N+1..N+1+CLKS_PER_BIT.
- A push on the same edge that the FSM pops (nonzero count) leaves the count unchanged. A push into a full FIFO that coincides with a pop is not accepted, because tx_ready is computed from the pre-edge count.
- Reset asserted mid-frame: after that edge tx_pin=1 and all state is at reset values. Reset has priority over push and pop.
- busy falls on the edge that returns the FSM to IDLE with an empty FIFO.

## Test plan
- CLKS_PER_BIT=4, 8N1: push 0xA5 at edge 0. tx_pin falls after edge 1, then shows 1,0,1,0,0,1,0,1 at 4 clocks each, stop high. busy falls after edge 41.
- 8O1 and 8E1: send 0x07. Required parity bit is 0 for odd and 1 for even. For 0x00, odd gives 1 and even gives 0.
- FIFO_DEPTH=4: hold tx_valid high with 6 words. tx_ready drops when fifo_count=4, and no word is lost or duplicated. Frames are back-to-back with the stop bit immediately followed by the next start bit, and every bit is 4 clocks.
- 7 data bits, 2 stop bits, CLKS_PER_BIT=3: frame is exactly 30 clocks, and stop high lasts 6 clocks.
- Reset at clock 10 of a frame with 2 words queued: tx_pin=1, fifo_count=0, busy=0 on the next cycle. A new push then transmits normally.
- Push on the same edge as a pop with fifo_count=2: fifo_count stays 2. With the FIFO full, tx_valid is ignored on that edge.

Source files
------------

// File: rtl/uart_tx_stream.sv
// UART transmitter with an input FIFO and a valid/ready byte stream interface.
// Baud timing comes from an enable counter, and frames are sent back to back with no idle gap.
module uart_tx_stream #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy,
    output logic                        tx_pin
);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW = PtrW + 1;
    localparam logic [CountW-1:0] Depth    = CountW'(FIFO_DEPTH);
    localparam logic [15:0]       BaudLast = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        DataLast = 4'(DATA_BITS - 1);
    localparam logic [3:0]        StopLast = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e               state_q;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q;
    logic [PtrW-1:0]      rd_ptr_q;
    logic [CountW-1:0]    count_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic [15:0]          baud_q;
    logic [3:0]           bit_q;
    logic                 tx_pin_q;

    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic                 frame_end;
    logic [DATA_BITS-1:0] head;

    always_comb begin
        head      = mem_q[rd_ptr_q];
        bit_end   = (baud_q == BaudLast);
        frame_end = (state_q == StStop) && bit_end && (bit_q == StopLast);
        push      = tx_valid && tx_ready;
        // Popping at the end of the last stop bit chains the next frame with no idle bit.
        pop       = (count_q != '0) && ((state_q == StIdle) || frame_end);
    end

    assign tx_ready   = (count_q < Depth);
    assign fifo_count = count_q;
    assign busy       = (state_q != StIdle) || (count_q != '0);
    assign tx_pin     = tx_pin_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            baud_q   <= '0;
            bit_q    <= '0;
            tx_pin_q <= 1'b1;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= tx_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end

            if (pop) begin
                shift_q  <= head;
                parity_q <= (PARITY == 1) ? ~^head : ^head;
                baud_q   <= '0;
                bit_q    <= '0;
                tx_pin_q <= 1'b0;
                state_q  <= StStart;
            end else if (state_q != StIdle) begin
                baud_q <= bit_end ? '0 : baud_q + 1'b1;
                if (bit_end) begin
                    unique case (state_q)
                        StStart: begin
                            tx_pin_q <= shift_q[0];
                            state_q  <= StData;
                        end
                        StData: begin
                            if (bit_q == DataLast) begin
                                bit_q <= '0;
                                if (PARITY != 0) begin
                                    tx_pin_q <= parity_q;
                                    state_q  <= StParity;
                                end else begin
                                    tx_pin_q <= 1'b1;
                                    state_q  <= StStop;
                                end
                            end else begin
                                bit_q    <= bit_q + 1'b1;
                                shift_q  <= shift_q >> 1;
                                tx_pin_q <= shift_q[1];
                            end
                        end
                        StParity: begin
                            tx_pin_q <= 1'b1;
                            state_q  <= StStop;
                        end
                        StStop: begin
                            if (bit_q == StopLast) begin
                                bit_q    <= '0;
                                tx_pin_q <= 1'b1;
                                state_q  <= StIdle;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: four frame formats checked cycle by cycle against a frame-level model
// that derives acceptance edges, frame start edges and line levels from arithmetic.
module tb_uart_tx_stream;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic [1:0] sel = 2'd0;

    logic [3:0] ready_w;
    logic [3:0] busy_w;
    logic [3:0] pin_w;
    logic [2:0] cnt0, cnt1, cnt2, cnt3;
    logic       ready_o, busy_o, pin_o;
    logic [2:0] cnt_o;

    int cpb_t  [4] = '{4, 4, 4, 3};
    int dbits_t[4] = '{8, 8, 8, 7};
    int par_t  [4] = '{0, 1, 2, 0};
    int stop_t [4] = '{1, 1, 1, 2};

    logic [7:0] words[$];
    bit         vpat [0:1023];
    int         checks = 0;
    int         failures = 0;

    always #5 clock = ~clock;

    uart_tx_stream #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                     .FIFO_DEPTH(4)) dut_8n1 (
        .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid && (sel == 2'd0)),
        .tx_ready(ready_w[0]), .fifo_count(cnt0), .busy(busy_w[0]), .tx_pin(pin_w[0]));
    uart_tx_stream #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                     .FIFO_DEPTH(4)) dut_8o1 (
        .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid && (sel == 2'd1)),
        .tx_ready(ready_w[1]), .fifo_count(cnt1), .busy(busy_w[1]), .tx_pin(pin_w[1]));
    uart_tx_stream #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                     .FIFO_DEPTH(4)) dut_8e1 (
        .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid && (sel == 2'd2)),
        .tx_ready(ready_w[2]), .fifo_count(cnt2), .busy(busy_w[2]), .tx_pin(pin_w[2]));
    uart_tx_stream #(.CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2),
                     .FIFO_DEPTH(4)) dut_7n2 (
        .clock(clock), .reset(reset), .tx_data(tx_data[6:0]),
        .tx_valid(tx_valid && (sel == 2'd3)),
        .tx_ready(ready_w[3]), .fifo_count(cnt3), .busy(busy_w[3]), .tx_pin(pin_w[3]));

    always_comb begin
        ready_o = ready_w[sel];
        busy_o  = busy_w[sel];
        pin_o   = pin_w[sel];
        case (sel)
            2'd0:    cnt_o = cnt0;
            2'd1:    cnt_o = cnt1;
            2'd2:    cnt_o = cnt2;
            default: cnt_o = cnt3;
        endcase
    end

    function automatic int frame_bits(input int s);
        return 1 + dbits_t[s] + ((par_t[s] != 0) ? 1 : 0) + stop_t[s];
    endfunction

    // Line level for bit position idx of a frame carrying w.
    function automatic bit frame_bit(input int s, input logic [7:0] w, input int idx);
        int ones;
        if (idx == 0) return 1'b0;
        if (idx <= dbits_t[s]) return w[idx-1];
        if (par_t[s] != 0 && idx == dbits_t[s] + 1) begin
            ones = 0;
            for (int i = 0; i < dbits_t[s]; i++) ones += int'(w[i]);
            return (par_t[s] == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        end
        return 1'b1;
    endfunction

    task automatic set_pat(input int mode);
        for (int i = 0; i < 1024; i++) begin
            if (mode == 1) vpat[i] = 1'b1;
            else if (mode == 2) vpat[i] = (i >= 60) || ($urandom_range(0, 1) == 1);
            else vpat[i] = 1'b0;
        end
    endtask

    task automatic rand_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(8'($urandom));
    endtask

    // Drives words per vpat on DUT s and checks every cycle; rst_at >= 0 pulses reset on that edge.
    task automatic run(input logic [1:0] s, input int rst_at, input string name);
        int acc[$];
        int st[$];
        int nxt, n, len, pre_cnt, m_cnt, start;
        bit m_pin, m_busy;
        sel = s;
        n   = words.size();
        nxt = 0;
        len = frame_bits(int'(s)) * cpb_t[s];
        @(negedge clock);
        for (int k = 0; k < 1000; k++) begin
            pre_cnt = acc.size();
            foreach (st[i]) if (st[i] <= k - 1) pre_cnt--;
            tx_valid = vpat[k] && (nxt < n);
            tx_data  = (nxt < n) ? words[nxt] : 8'h00;
            reset    = (k == rst_at);
            if (tx_valid && pre_cnt < 4 && k != rst_at) begin
                start = k + 1;
                if (nxt > 0 && st[nxt-1] + len > start) start = st[nxt-1] + len;
                acc.push_back(k);
                st.push_back(start);
                nxt++;
            end
            @(negedge clock);
            if (k == rst_at) begin
                reset    = 1'b0;
                tx_valid = 1'b0;
                checks++;
                if (pin_o !== 1'b1 || cnt_o !== 3'd0 || busy_o !== 1'b0 || ready_o !== 1'b1) begin
                    failures++;
                    $display("FAIL %s reset_state got pin=%b cnt=%0d busy=%b ready=%b exp 1 0 0 1",
                             name, pin_o, cnt_o, busy_o, ready_o);
                end
                return;
            end
            m_cnt  = acc.size();
            m_pin  = 1'b1;
            m_busy = 1'b0;
            foreach (st[f]) begin
                if (st[f] <= k) begin
                    m_cnt--;
                    if (k < st[f] + len) begin
                        m_busy = 1'b1;
                        m_pin  = frame_bit(int'(s), words[f], (k - st[f]) / cpb_t[s]);
                    end
                end
            end
            if (m_cnt > 0) m_busy = 1'b1;
            checks++;
            if (pin_o !== m_pin) begin
                failures++;
                $display("FAIL %s tx_pin edge=%0d got=%b exp=%b", name, k, pin_o, m_pin);
            end
            checks++;
            if (cnt_o !== 3'(m_cnt)) begin
                failures++;
                $display("FAIL %s fifo_count edge=%0d got=%0d exp=%0d", name, k, cnt_o, m_cnt);
            end
            checks++;
            if (busy_o !== m_busy) begin
                failures++;
                $display("FAIL %s busy edge=%0d got=%b exp=%b", name, k, busy_o, m_busy);
            end
            checks++;
            if (ready_o !== (m_cnt < 4)) begin
                failures++;
                $display("FAIL %s tx_ready edge=%0d got=%b exp=%b", name, k, ready_o, m_cnt < 4);
            end
            if (n > 0 && nxt == n && k >= st[n-1] + len) begin
                tx_valid = 1'b0;
                return;
            end
        end
        tx_valid = 1'b0;
        checks++;
        failures++;
        $display("FAIL %s timeout got=running exp=idle", name);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        tx_valid = 1'b0;
        repeat (3) @(negedge clock);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            checks++;
            if (pin_o !== 1'b1 || cnt_o !== 3'd0 || busy_o !== 1'b0 || ready_o !== 1'b1) begin
                failures++;
                $display("FAIL reset dut=%0d got pin=%b cnt=%0d busy=%b ready=%b exp 1 0 0 1",
                         s, pin_o, cnt_o, busy_o, ready_o);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        words.delete();
        words.push_back(8'hA5);
        set_pat(0);
        vpat[0] = 1'b1;
        run(2'd0, -1, "basic_8n1");
    endtask

    task automatic test_parity();
        for (int s = 1; s <= 2; s++) begin
            words.delete();
            words.push_back(8'h07);
            words.push_back(8'h00);
            words.push_back(8'($urandom));
            set_pat(1);
            run(2'(s), -1, (s == 1) ? "parity_odd" : "parity_even");
        end
    endtask

    task automatic test_back_to_back();
        rand_words(6);
        set_pat(1);
        run(2'd0, -1, "back_to_back");
    endtask

    task automatic test_two_stop();
        rand_words(3);
        set_pat(1);
        run(2'd3, -1, "7n2_cpb3");
    endtask

    task automatic test_same_edge();
        rand_words(4);
        set_pat(0);
        vpat[0]  = 1'b1;
        vpat[1]  = 1'b1;
        vpat[2]  = 1'b1;
        vpat[41] = 1'b1;
        run(2'd0, -1, "push_on_pop");
    endtask

    task automatic test_reset_midframe();
        rand_words(3);
        set_pat(0);
        vpat[0] = 1'b1;
        vpat[1] = 1'b1;
        vpat[2] = 1'b1;
        run(2'd0, 11, "reset_mid");
        rand_words(2);
        set_pat(1);
        run(2'd0, -1, "after_reset");
    endtask

    task automatic test_random();
        for (int s = 0; s < 4; s++) begin
            rand_words(5);
            set_pat(2);
            run(2'(s), -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_two_stop();
        test_same_edge();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
